// File: rtl/surf_cout_align_ctrl.sv
// Training sequencer for one SURF COUT/DOUT input path. It sweeps the IDELAY taps to find the
// widest error-free eye, loads the eye centre, then bitslips until captures match the pattern.
module surf_cout_align_ctrl #(
  parameter int unsigned MAX_TAP       = 31,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLES       = 4,
  parameter int unsigned MIN_EYE       = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        target_i,
  input  logic [31:0] train_pattern_i,
  output logic        iserdes_rst_o,
  output logic [5:0]  idelay_value_o,
  output logic        idelay_cout_load_o,
  output logic        idelay_dout_load_o,
  output logic        iserdes_cout_bitslip_o,
  output logic        iserdes_dout_bitslip_o,
  output logic        cout_capture_o,
  output logic        dout_capture_o,
  input  logic [31:0] cout_data_i,
  input  logic        cout_valid_i,
  input  logic        cout_biterr_i,
  input  logic [7:0]  dout_data_i,
  input  logic        dout_valid_i,
  input  logic        dout_biterr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [5:0]  eye_start_o,
  output logic [6:0]  eye_width_o,
  output logic [3:0]  bitslips_o
);

  localparam logic [15:0] RstLast     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SettleLast  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  localparam logic [7:0]  SamplesLast = 8'(SAMPLES - 1);
  localparam logic [5:0]  MaxTap      = 6'(MAX_TAP);
  localparam logic [6:0]  MinEye      = 7'(MIN_EYE);

  typedef enum logic [3:0] {
    StIdle, StPrst, StLoad, StSettle, StSample, StSampWait, StCenter, StCload,
    StCsettle, StSlipChk, StSlipWait, StSlip, StSsettle, StDone, StFail
  } state_e;

  state_e      state_q, state_d;
  logic        target_q, target_d;
  logic [31:0] pattern_q, pattern_d;
  logic [5:0]  tap_q, tap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  smp_q, smp_d;
  logic [5:0]  run_start_q, run_start_d;
  logic [6:0]  run_len_q, run_len_d;
  logic [5:0]  best_start_q, best_start_d;
  logic [6:0]  best_width_q, best_width_d;
  logic [3:0]  slips_q, slips_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic        sel_valid, sel_biterr, sel_match;
  logic [3:0]  max_slips;
  logic        load_stb, slip_stb, cap_stb;
  logic        tap_end, tap_good;
  logic [5:0]  cand_start;
  logic [6:0]  cand_len;

  assign sel_valid  = target_q ? dout_valid_i : cout_valid_i;
  assign sel_biterr = target_q ? dout_biterr_i : cout_biterr_i;
  assign sel_match  = target_q ? (dout_data_i == pattern_q[7:0]) : (cout_data_i == pattern_q);
  assign max_slips  = target_q ? 4'd7 : 4'd3;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    pattern_d    = pattern_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    smp_d        = smp_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_width_d = best_width_q;
    slips_d      = slips_q;
    done_d       = done_q;
    fail_d       = fail_q;
    iserdes_rst_o = 1'b0;
    load_stb     = 1'b0;
    slip_stb     = 1'b0;
    cap_stb      = 1'b0;
    tap_end      = 1'b0;
    tap_good     = 1'b0;
    cand_start   = run_start_q;
    cand_len     = run_len_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          target_d     = target_i;
          pattern_d    = train_pattern_i;
          tap_d        = '0;
          cnt_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_width_d = '0;
          slips_d      = '0;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          state_d      = StPrst;
        end
      end
      StPrst: begin
        iserdes_rst_o = 1'b1;
        tap_d         = '0;
        if (cnt_q == RstLast) begin
          cnt_d   = '0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StLoad: begin
        load_stb = 1'b1;
        cnt_d    = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          smp_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StSample: begin
        cap_stb = 1'b1;
        cnt_d   = '0;
        state_d = StSampWait;
      end
      StSampWait: begin
        if (sel_valid) begin
          if (sel_biterr) begin
            tap_end = 1'b1;
          end else if (smp_q == SamplesLast) begin
            tap_end  = 1'b1;
            tap_good = 1'b1;
          end else begin
            smp_d   = smp_q + 8'd1;
            state_d = StSample;
          end
        end else if (cnt_q == TimeoutLast) begin
          tap_end = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StCenter: begin
        if (best_width_q < MinEye) begin
          fail_d  = 1'b1;
          state_d = StFail;
        end else begin
          tap_d   = best_start_q + best_width_q[6:1];
          state_d = StCload;
        end
      end
      StCload: begin
        load_stb = 1'b1;
        cnt_d    = '0;
        state_d  = StCsettle;
      end
      StCsettle, StSsettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StSlipChk;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StSlipChk: begin
        cap_stb = 1'b1;
        cnt_d   = '0;
        state_d = StSlipWait;
      end
      StSlipWait: begin
        // A timed-out capture is treated as a mismatch and costs a bitslip.
        if (sel_valid || (cnt_q == TimeoutLast)) begin
          if (sel_valid && sel_match && !sel_biterr) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else if (slips_q == max_slips) begin
            fail_d  = 1'b1;
            state_d = StFail;
          end else begin
            state_d = StSlip;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StSlip: begin
        slip_stb = 1'b1;
        slips_d  = slips_q + 4'd1;
        cnt_d    = '0;
        state_d  = StSsettle;
      end
      StDone, StFail: state_d = StIdle;
      default:        state_d = StIdle;
    endcase

    // Close the current run on a bad tap or at the last tap; ties keep the earlier eye.
    if (tap_end) begin
      if (tap_good) begin
        if (run_len_q == 7'd0) cand_start = tap_q;
        cand_len = run_len_q + 7'd1;
      end
      if (!tap_good || (tap_q == MaxTap)) begin
        if (cand_len > best_width_q) begin
          best_start_d = cand_start;
          best_width_d = cand_len;
        end
        run_len_d = '0;
      end else begin
        run_start_d = cand_start;
        run_len_d   = cand_len;
      end
      if (tap_q == MaxTap) begin
        state_d = StCenter;
      end else begin
        tap_d   = tap_q + 6'd1;
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      target_q     <= 1'b0;
      pattern_q    <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      smp_q        <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_width_q <= '0;
      slips_q      <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      pattern_q    <= pattern_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      smp_q        <= smp_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_width_q <= best_width_d;
      slips_q      <= slips_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign idelay_value_o         = tap_q;
  assign idelay_cout_load_o     = load_stb & ~target_q;
  assign idelay_dout_load_o     = load_stb & target_q;
  assign iserdes_cout_bitslip_o = slip_stb & ~target_q;
  assign iserdes_dout_bitslip_o = slip_stb & target_q;
  assign cout_capture_o         = cap_stb & ~target_q;
  assign dout_capture_o         = cap_stb & target_q;
  assign busy_o      = (state_q != StIdle) && (state_q != StDone) && (state_q != StFail);
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign eye_start_o = best_start_q;
  assign eye_width_o = best_width_q;
  assign bitslips_o  = slips_q;

endmodule
